// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer pixel writer/reader blocks.
// Holds the FSM encoding, field-width defaults and the pixel address helper.
package fb_pkg;

   localparam int unsigned LINE_LEN_DEF  = 9;
   localparam int unsigned COL_LEN_DEF   = 10;
   localparam int unsigned COLOR_W_DEF   = 32;
   localparam int unsigned ROW_SHIFT_DEF = 10;
   localparam logic [31:0] FB_BASE_DEF   = 32'h9000_0000;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      REQ,
      WAIT_CMPLT,
      ERR
   } fb_state_e;

   // Byte address of a pixel: base + ((line * pitch) + col) * 4.
   // Returned wide; callers truncate to their bus width (wraps modulo 2^AW).
   function automatic logic [63:0] pixel_addr(
      input logic [31:0] line,
      input logic [31:0] col,
      input logic [63:0] base      = 64'(FB_BASE_DEF),
      input int unsigned row_shift = ROW_SHIFT_DEF
   );
      logic [63:0] pix;
      pix = (64'(line) << row_shift) + 64'(col);
      return base + (pix << 2);
   endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Bounds check and framebuffer address generation for one pixel.
// Range flag is available combinationally for the load decision and also registered.
module fb_addr_gen
   import fb_pkg::*;
#(
   parameter int unsigned LINE_LEN     = LINE_LEN_DEF,
   parameter int unsigned COL_LEN      = COL_LEN_DEF,
   parameter int unsigned C_MST_AWIDTH = 32,
   parameter logic [C_MST_AWIDTH-1:0] FB_BASE = C_MST_AWIDTH'(FB_BASE_DEF),
   parameter int unsigned ROW_SHIFT    = ROW_SHIFT_DEF,
   parameter int unsigned MAX_LINES    = 480,
   parameter int unsigned MAX_COLS     = 640
) (
   input  logic                    PLB_clk,
   input  logic                    PLB_rst_n,
   input  logic                    ld,
   input  logic [LINE_LEN-1:0]     line,
   input  logic [COL_LEN-1:0]      col,
   output logic                    oor,
   output logic                    oor_q,
   output logic [C_MST_AWIDTH-1:0] addr_q
);

   logic [63:0] addr_full;

   assign oor       = (32'(line) >= MAX_LINES) || (32'(col) >= MAX_COLS);
   assign addr_full = pixel_addr(32'(line), 32'(col), 64'(FB_BASE), ROW_SHIFT);

   always_ff @(posedge PLB_clk or negedge PLB_rst_n) begin
      if (!PLB_rst_n) begin
         oor_q  <= 1'b0;
         addr_q <= '0;
      end else if (ld) begin
         oor_q  <= oor;
         addr_q <= addr_full[C_MST_AWIDTH-1:0];
      end
   end

endmodule

// File: rtl/fb_pixel_writer.sv
// PLB master that drains rasteriser pixel packets and writes them to the framebuffer,
// one single-beat write per pixel, with bounded retry and saturating status counters.
module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int unsigned LINE_LEN          = LINE_LEN_DEF,
   parameter int unsigned COL_LEN           = COL_LEN_DEF,
   parameter int unsigned COLOR_W           = COLOR_W_DEF,
   parameter int unsigned RAST_FBW_FIFO_LEN = 64,
   parameter int unsigned C_MST_AWIDTH      = 32,
   parameter int unsigned C_MST_DWIDTH      = 32,
   parameter logic [C_MST_AWIDTH-1:0] FB_BASE = C_MST_AWIDTH'(FB_BASE_DEF),
   parameter int unsigned ROW_SHIFT         = ROW_SHIFT_DEF,
   parameter int unsigned MAX_LINES         = 480,
   parameter int unsigned MAX_COLS          = 640,
   parameter int unsigned MAX_RETRY         = 3,
   parameter int unsigned CNT_W             = 32
) (
   input  logic                        PLB_clk,
   input  logic                        PLB_rst_n,
   input  logic                        enable,
   input  logic [RAST_FBW_FIFO_LEN-1:0] fifo_data,
   input  logic                        fifo_empty,
   output logic                        fifo_rd_en,
   output logic                        IP2Bus_MstRd_Req,
   output logic                        IP2Bus_MstWr_Req,
   output logic [C_MST_AWIDTH-1:0]     IP2Bus_Mst_Addr,
   output logic [C_MST_DWIDTH/8-1:0]   IP2Bus_Mst_BE,
   output logic                        IP2Bus_Mst_Lock,
   output logic                        IP2Bus_Mst_Reset,
   input  logic                        Bus2IP_Mst_CmdAck,
   input  logic                        Bus2IP_Mst_Cmplt,
   input  logic                        Bus2IP_Mst_Error,
   input  logic                        Bus2IP_Mst_Rearbitrate,
   input  logic                        Bus2IP_Mst_Cmd_Timeout,
   output logic [C_MST_DWIDTH-1:0]     IP2Bus_MstWr_d,
   input  logic                        Bus2IP_MstWr_dst_rdy_n,
   output logic                        busy,
   output logic [CNT_W-1:0]            pix_written,
   output logic [CNT_W-1:0]            pix_dropped
);

   localparam int unsigned TOP = RAST_FBW_FIFO_LEN - 1;
   localparam int unsigned RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   fb_state_e state_q, state_d;

   logic [LINE_LEN-1:0] f_line;
   logic [COL_LEN-1:0]  f_col;
   logic [COLOR_W-1:0]  f_color;
   logic [COLOR_W-1:0]  color_q;
   logic [RW-1:0]       retry_q;

   logic      ld, oor, oor_q;
   logic      wr_inc, drop_inc, retry_clr, retry_inc;
   fb_state_e cmpl_state;
   logic      cmpl_wr;
   logic      unused_ok;

   // Packet is packed from the top of the FIFO word down; leftover low bits are padding.
   assign f_line  = fifo_data[TOP -: LINE_LEN];
   assign f_col   = fifo_data[TOP-LINE_LEN -: COL_LEN];
   assign f_color = fifo_data[TOP-LINE_LEN-COL_LEN -: COLOR_W];

   // Single-beat writes never need the data-phase handshake.
   assign unused_ok = ^{fifo_data, Bus2IP_MstWr_dst_rdy_n, oor_q};

   fb_addr_gen #(
      .LINE_LEN     (LINE_LEN),
      .COL_LEN      (COL_LEN),
      .C_MST_AWIDTH (C_MST_AWIDTH),
      .FB_BASE      (FB_BASE),
      .ROW_SHIFT    (ROW_SHIFT),
      .MAX_LINES    (MAX_LINES),
      .MAX_COLS     (MAX_COLS)
   ) u_addr_gen (
      .PLB_clk   (PLB_clk),
      .PLB_rst_n (PLB_rst_n),
      .ld        (ld),
      .line      (f_line),
      .col       (f_col),
      .oor       (oor),
      .oor_q     (oor_q),
      .addr_q    (IP2Bus_Mst_Addr)
   );

   // Outcome of a completed command; shared by the REQ fast path and WAIT_CMPLT.
   always_comb begin
      cmpl_state = IDLE;
      cmpl_wr    = 1'b0;
      if (Bus2IP_Mst_Error || Bus2IP_Mst_Cmd_Timeout) cmpl_state = ERR;
      else if (Bus2IP_Mst_Rearbitrate)                 cmpl_state = REQ;
      else                                             cmpl_wr    = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      ld        = 1'b0;
      wr_inc    = 1'b0;
      drop_inc  = 1'b0;
      retry_clr = 1'b0;
      retry_inc = 1'b0;
      case (state_q)
         IDLE: if (enable && !fifo_empty) state_d = POP;
         POP:  state_d = LOAD;
         LOAD: begin
            ld = 1'b1;
            if (oor) begin
               drop_inc = 1'b1;
               state_d  = IDLE;
            end else begin
               retry_clr = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (!Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmd_Timeout) begin
               state_d = ERR;
            end else if (Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt) begin
               state_d = cmpl_state;
               wr_inc  = cmpl_wr;
            end else if (Bus2IP_Mst_CmdAck) begin
               state_d = WAIT_CMPLT;
            end
         end
         WAIT_CMPLT: if (Bus2IP_Mst_Cmplt) begin
            state_d = cmpl_state;
            wr_inc  = cmpl_wr;
         end
         ERR: begin
            if (retry_q < RW'(MAX_RETRY)) begin
               retry_inc = 1'b1;
               state_d   = REQ;
            end else begin
               drop_inc = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PLB_clk or negedge PLB_rst_n) begin
      if (!PLB_rst_n) begin
         state_q     <= IDLE;
         color_q     <= '0;
         retry_q     <= '0;
         pix_written <= '0;
         pix_dropped <= '0;
      end else begin
         state_q <= state_d;
         if (ld)             color_q <= f_color;
         if (retry_clr)      retry_q <= '0;
         else if (retry_inc) retry_q <= retry_q + RW'(1);
         if (wr_inc && (pix_written != '1))   pix_written <= pix_written + CNT_W'(1);
         if (drop_inc && (pix_dropped != '1)) pix_dropped <= pix_dropped + CNT_W'(1);
      end
   end

   assign fifo_rd_en       = (state_q == POP);
   assign IP2Bus_MstWr_Req = (state_q == REQ);
   assign IP2Bus_Mst_Reset = (state_q == ERR);
   assign busy             = (state_q != IDLE);
   assign IP2Bus_MstRd_Req = 1'b0;
   assign IP2Bus_Mst_Lock  = 1'b0;
   assign IP2Bus_Mst_BE    = '1;
   assign IP2Bus_MstWr_d   = C_MST_DWIDTH'(color_q);

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: a FIFO model feeds packets, a scripted PLB
// responder answers writes, and every clean completion is checked against the queue.
module tb_fb_pixel_writer;

   localparam logic [31:0] BASE = 32'h9000_0000;

   logic        PLB_clk = 1'b0;
   logic        PLB_rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [63:0] fifo_data = '0;
   logic        fifo_empty = 1'b1;
   logic        fifo_rd_en;
   logic        IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Lock, IP2Bus_Mst_Reset;
   logic [31:0] IP2Bus_Mst_Addr, IP2Bus_MstWr_d;
   logic [3:0]  IP2Bus_Mst_BE;
   logic        Bus2IP_Mst_CmdAck = 1'b0, Bus2IP_Mst_Cmplt = 1'b0, Bus2IP_Mst_Error = 1'b0;
   logic        Bus2IP_Mst_Rearbitrate = 1'b0, Bus2IP_Mst_Cmd_Timeout = 1'b0;
   logic        Bus2IP_MstWr_dst_rdy_n = 1'b1;
   logic        busy;
   logic [31:0] pix_written, pix_dropped;

   always #5 PLB_clk = ~PLB_clk;

   fb_pixel_writer dut (
      .PLB_clk(PLB_clk), .PLB_rst_n(PLB_rst_n), .enable(enable),
      .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .IP2Bus_MstRd_Req(IP2Bus_MstRd_Req), .IP2Bus_MstWr_Req(IP2Bus_MstWr_Req),
      .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr), .IP2Bus_Mst_BE(IP2Bus_Mst_BE),
      .IP2Bus_Mst_Lock(IP2Bus_Mst_Lock), .IP2Bus_Mst_Reset(IP2Bus_Mst_Reset),
      .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck), .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt),
      .Bus2IP_Mst_Error(Bus2IP_Mst_Error), .Bus2IP_Mst_Rearbitrate(Bus2IP_Mst_Rearbitrate),
      .Bus2IP_Mst_Cmd_Timeout(Bus2IP_Mst_Cmd_Timeout), .IP2Bus_MstWr_d(IP2Bus_MstWr_d),
      .Bus2IP_MstWr_dst_rdy_n(Bus2IP_MstWr_dst_rdy_n), .busy(busy),
      .pix_written(pix_written), .pix_dropped(pix_dropped)
   );

   typedef struct packed { logic [31:0] addr; logic [31:0] data; } exp_t;

   int          vectors = 0, miscompares = 0;
   logic [63:0] fifo_q[$];
   exp_t        sb[$];
   int          script[$];   // per attempt: 0 ok, 1 error, 2 rearbitrate, 3 timeout before ack
   bit          split = 0, hold_cmplt = 0, pend = 0, prev_req = 0;
   int          code_cur = 0;
   int          pops = 0, req_eps = 0, mst_resets = 0;
   int          exp_written = 0, exp_dropped = 0;

   // FIFO model and event monitor.
   always @(negedge PLB_clk) begin
      if (fifo_rd_en) begin
         pops++;
         if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
         else begin
            vectors++; miscompares++;
            $display("FAIL pop_on_empty pops=%0d required queue non-empty", pops);
         end
      end
      fifo_empty = (fifo_q.size() == 0);
      if (IP2Bus_Mst_Reset) mst_resets++;
      if (IP2Bus_MstWr_Req && !prev_req) req_eps++;
      prev_req = IP2Bus_MstWr_Req;
   end

   // Scripted PLB responder; clean completions are checked against the scoreboard.
   always @(negedge PLB_clk) begin
      exp_t e;
      Bus2IP_Mst_CmdAck = 0; Bus2IP_Mst_Cmplt = 0; Bus2IP_Mst_Error = 0;
      Bus2IP_Mst_Rearbitrate = 0; Bus2IP_Mst_Cmd_Timeout = 0;
      if (!PLB_rst_n) pend = 0;
      else begin
         if (pend) begin
            if (!hold_cmplt) begin
               Bus2IP_Mst_Cmplt = 1; pend = 0;
            end
         end else if (IP2Bus_MstWr_Req) begin
            code_cur = (script.size() > 0) ? script.pop_front() : 0;
            if (code_cur == 3) Bus2IP_Mst_Cmd_Timeout = 1;
            else begin
               Bus2IP_Mst_CmdAck = 1;
               if (split) pend = 1;
               else Bus2IP_Mst_Cmplt = 1;
            end
         end
         if (Bus2IP_Mst_Cmplt) begin
            Bus2IP_Mst_Error       = (code_cur == 1);
            Bus2IP_Mst_Rearbitrate = (code_cur == 2);
            if (code_cur == 0) begin
               vectors++;
               if (sb.size() == 0) begin
                  miscompares++;
                  $display("FAIL sb_underflow addr=%h data=%h with no write expected",
                           IP2Bus_Mst_Addr, IP2Bus_MstWr_d);
               end else begin
                  e = sb.pop_front();
                  if (IP2Bus_Mst_Addr !== e.addr || IP2Bus_MstWr_d !== e.data) begin
                     miscompares++;
                     $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                              IP2Bus_Mst_Addr, IP2Bus_MstWr_d, e.addr, e.data);
                  end
               end
            end
         end
      end
   end

   task automatic push_pix(input int line, input int col, input logic [31:0] color,
                           input bit expect_wr);
      logic [63:0] w;
      exp_t        e;
      w = '0;
      w[63 -: 9]  = 9'(line);
      w[54 -: 10] = 10'(col);
      w[44 -: 32] = color;
      e.addr = BASE + 32'((line * 1024 + col) * 4);
      e.data = color;
      if (expect_wr) sb.push_back(e);
      fifo_q.push_back(w);
      fifo_empty = 0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge PLB_clk);
      while ((fifo_q.size() != 0 || busy || pend) && n < 400) begin
         @(negedge PLB_clk); n++;
      end
      vectors++;
      if (n >= 400) begin
         miscompares++;
         $display("FAIL %s_idle_timeout busy=%b queued=%0d required idle", name, busy,
                  fifo_q.size());
      end
   endtask

   task automatic test_reset;
      PLB_rst_n = 0; enable = 0;
      repeat (3) @(negedge PLB_clk);
      vectors += 5;
      if ({IP2Bus_MstWr_Req, fifo_rd_en, busy, IP2Bus_Mst_Reset, IP2Bus_MstRd_Req,
           IP2Bus_Mst_Lock} !== 6'b0) begin
         miscompares++; $display("FAIL reset_ctrl got %b required 000000",
            {IP2Bus_MstWr_Req, fifo_rd_en, busy, IP2Bus_Mst_Reset, IP2Bus_MstRd_Req,
             IP2Bus_Mst_Lock});
      end
      if (pix_written !== 0) begin miscompares++; $display("FAIL reset_written got %0d required 0", pix_written); end
      if (pix_dropped !== 0) begin miscompares++; $display("FAIL reset_dropped got %0d required 0", pix_dropped); end
      if (IP2Bus_Mst_Addr !== 0) begin miscompares++; $display("FAIL reset_addr got %h required 0", IP2Bus_Mst_Addr); end
      if (IP2Bus_MstWr_d !== 0) begin miscompares++; $display("FAIL reset_data got %h required 0", IP2Bus_MstWr_d); end
      PLB_rst_n = 1;
      @(negedge PLB_clk);
      enable = 1;
   endtask

   task automatic test_single_write;
      int r0, p0, m0;
      r0 = req_eps; p0 = pops; m0 = mst_resets;
      push_pix(5, 7, 32'hDEAD_BEEF, 1);
      wait_idle("single");
      exp_written++;
      vectors += 6;
      if (pix_written !== 32'(exp_written)) begin miscompares++; $display("FAIL single_written got %0d required %0d", pix_written, exp_written); end
      if (req_eps - r0 !== 1) begin miscompares++; $display("FAIL single_reqs got %0d required 1", req_eps - r0); end
      if (pops - p0 !== 1) begin miscompares++; $display("FAIL single_pops got %0d required 1", pops - p0); end
      if (mst_resets !== m0) begin miscompares++; $display("FAIL single_mst_reset got %0d required %0d", mst_resets, m0); end
      if (IP2Bus_Mst_Addr !== 32'h9000_501C || IP2Bus_MstWr_d !== 32'hDEAD_BEEF) begin
         miscompares++; $display("FAIL single_addr_data got %h/%h required 9000501c/deadbeef",
                                 IP2Bus_Mst_Addr, IP2Bus_MstWr_d);
      end
      if (IP2Bus_Mst_BE !== 4'hF) begin miscompares++; $display("FAIL single_be got %h required f", IP2Bus_Mst_BE); end
   endtask

   task automatic test_out_of_range;
      int r0;
      r0 = req_eps;
      push_pix(480, 0, 32'h1111_1111, 0);
      exp_dropped++;
      repeat (2) @(negedge PLB_clk);
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL oor_busy_load got %b required 1", busy); end
      @(negedge PLB_clk);
      vectors += 2;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL oor_idle_3cyc got busy=%b required 0", busy); end
      if (pix_dropped !== 32'(exp_dropped)) begin miscompares++; $display("FAIL oor_line_dropped got %0d required %0d", pix_dropped, exp_dropped); end
      push_pix(0, 640, 32'h2222_2222, 0);
      exp_dropped++;
      push_pix(479, 639, 32'h3333_3333, 1);
      exp_written++;
      wait_idle("oor");
      vectors += 4;
      if (pix_dropped !== 32'(exp_dropped)) begin miscompares++; $display("FAIL oor_col_dropped got %0d required %0d", pix_dropped, exp_dropped); end
      if (pix_written !== 32'(exp_written)) begin miscompares++; $display("FAIL oor_edge_written got %0d required %0d", pix_written, exp_written); end
      if (req_eps - r0 !== 1) begin miscompares++; $display("FAIL oor_reqs got %0d required 1", req_eps - r0); end
      if (IP2Bus_Mst_Addr !== 32'h901D_F9FC) begin miscompares++; $display("FAIL oor_edge_addr got %h required 901df9fc", IP2Bus_Mst_Addr); end
   endtask

   task automatic test_error_retry;
      int r0, m0;
      r0 = req_eps; m0 = mst_resets;
      script = '{1, 1, 1, 1};
      push_pix(10, 20, 32'h1234_5678, 0);
      exp_dropped++;
      wait_idle("err");
      vectors += 4;
      if (req_eps - r0 !== 4) begin miscompares++; $display("FAIL err_reqs got %0d required 4", req_eps - r0); end
      if (mst_resets - m0 !== 4) begin miscompares++; $display("FAIL err_mst_resets got %0d required 4", mst_resets - m0); end
      if (pix_dropped !== 32'(exp_dropped)) begin miscompares++; $display("FAIL err_dropped got %0d required %0d", pix_dropped, exp_dropped); end
      if (pix_written !== 32'(exp_written)) begin miscompares++; $display("FAIL err_written got %0d required %0d", pix_written, exp_written); end
   endtask

   task automatic test_rearb;
      int r0, m0;
      r0 = req_eps; m0 = mst_resets;
      split = 1;
      script = '{2, 2, 0};
      push_pix(100, 300, 32'hCAFE_F00D, 1);
      exp_written++;
      wait_idle("rearb");
      split = 0;
      vectors += 3;
      if (req_eps - r0 !== 3) begin miscompares++; $display("FAIL rearb_reqs got %0d required 3", req_eps - r0); end
      if (mst_resets !== m0) begin miscompares++; $display("FAIL rearb_mst_reset got %0d required 0", mst_resets - m0); end
      if (pix_written !== 32'(exp_written)) begin miscompares++; $display("FAIL rearb_written got %0d required %0d", pix_written, exp_written); end
   endtask

   task automatic test_timeout;
      int r0, m0;
      r0 = req_eps; m0 = mst_resets;
      script = '{3, 0};
      push_pix(1, 1, 32'h0BAD_CAFE, 1);
      exp_written++;
      wait_idle("timeout");
      vectors += 3;
      if (req_eps - r0 !== 2) begin miscompares++; $display("FAIL timeout_reqs got %0d required 2", req_eps - r0); end
      if (mst_resets - m0 !== 1) begin miscompares++; $display("FAIL timeout_mst_reset got %0d required 1", mst_resets - m0); end
      if (pix_written !== 32'(exp_written)) begin miscompares++; $display("FAIL timeout_written got %0d required %0d", pix_written, exp_written); end
   endtask

   task automatic test_back_to_back;
      int p0, w0, n;
      p0 = pops; w0 = exp_written; n = 0;
      for (int i = 0; i < 8; i++) push_pix(i * 3, i * 5 + 1, 32'hA500_0000 | 32'(i), 1);
      while (pops - p0 < 3 && n < 200) begin @(negedge PLB_clk); n++; end
      enable = 0;
      repeat (20) @(negedge PLB_clk);
      vectors += 2;
      if (pops - p0 !== 3) begin miscompares++; $display("FAIL b2b_pops_while_disabled got %0d required 3", pops - p0); end
      if (pix_written !== 32'(w0 + 3)) begin miscompares++; $display("FAIL b2b_written_disabled got %0d required %0d", pix_written, w0 + 3); end
      enable = 1;
      exp_written += 8;
      wait_idle("b2b");
      vectors += 3;
      if (pix_written !== 32'(exp_written)) begin miscompares++; $display("FAIL b2b_written got %0d required %0d", pix_written, exp_written); end
      if (pops - p0 !== 8) begin miscompares++; $display("FAIL b2b_pops got %0d required 8", pops - p0); end
      if (sb.size() !== 0) begin miscompares++; $display("FAIL b2b_sb_left got %0d required 0", sb.size()); end
   endtask

   task automatic test_reset_midflight;
      int n;
      n = 0;
      split = 1; hold_cmplt = 1;
      push_pix(7, 9, 32'h5555_AAAA, 1);
      while (!pend && n < 100) begin @(negedge PLB_clk); n++; end
      @(negedge PLB_clk);
      vectors++;
      if (busy !== 1'b1 || IP2Bus_MstWr_Req !== 1'b0) begin
         miscompares++; $display("FAIL mid_wait_state got busy=%b req=%b required 1/0", busy, IP2Bus_MstWr_Req);
      end
      #2 PLB_rst_n = 0;
      #1;
      vectors += 3;
      if ({busy, IP2Bus_MstWr_Req, fifo_rd_en, IP2Bus_Mst_Reset} !== 4'b0) begin
         miscompares++; $display("FAIL mid_reset_ctrl got %b required 0000",
                                 {busy, IP2Bus_MstWr_Req, fifo_rd_en, IP2Bus_Mst_Reset});
      end
      if (pix_written !== 0 || pix_dropped !== 0) begin
         miscompares++; $display("FAIL mid_reset_counters got %0d/%0d required 0/0", pix_written, pix_dropped);
      end
      if (IP2Bus_Mst_Addr !== 0 || IP2Bus_MstWr_d !== 0) begin
         miscompares++; $display("FAIL mid_reset_addr_data got %h/%h required 0/0", IP2Bus_Mst_Addr, IP2Bus_MstWr_d);
      end
      sb.delete();
      exp_written = 0; exp_dropped = 0;
      hold_cmplt = 0; split = 0; pend = 0;
      @(negedge PLB_clk);
      PLB_rst_n = 1;
      @(negedge PLB_clk);
      push_pix(2, 3, 32'h7777_8888, 1);
      exp_written++;
      wait_idle("post_reset");
      vectors += 2;
      if (pix_written !== 32'(exp_written) || pix_dropped !== 0) begin
         miscompares++; $display("FAIL post_reset_counters got %0d/%0d required %0d/0", pix_written, pix_dropped, exp_written);
      end
      if (IP2Bus_Mst_Addr !== 32'h9000_200C) begin miscompares++; $display("FAIL post_reset_addr got %h required 9000200c", IP2Bus_Mst_Addr); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_out_of_range();
      test_error_retry();
      test_rearb();
      test_timeout();
      test_back_to_back();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
